aes_sub_bytes_seq: RTL and testbench

Parametrised, time-multiplexed AES SubBytes/InvSubBytes engine for the AES datapath. It accepts a state word of NUM_BYTES bytes over a valid/ready handshake and substitutes it through NUM_SBOX shared S-box lanes, NUM_SBOX bytes per cycle. Each word carries a per-transaction forward/inverse mode bit. The result is presented on a valid/ready output port. It sits between AddRoundKey and ShiftRows in the round datapath and trades area against throughput through NUM_SBOX.

---
 rtl/aes_pkg.sv | 48 ++++
 rtl/aes_sbox_lane.sv | 13 +
 rtl/aes_sub_bytes_seq.sv | 104 ++++++++++
 tb/tb_aes_sub_bytes_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and S-box tables for the AES SubBytes engine.
package aes_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

   // FIPS-197 forward S-box, indexed by input byte.
   localparam byte_t SBOX_FWD [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Inverse S-box: SBOX_INV[SBOX_FWD[x]] == x.
   localparam byte_t SBOX_INV [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane: forward or inverse substitution of a byte.
module aes_sbox_lane
   import aes_pkg::*;
(
   input  byte_t byte_i,
   input  logic  inv_i,
   output byte_t byte_o
);

   // Both tables are looked up in parallel; inv_i picks the result.
   assign byte_o = inv_i ? SBOX_INV[byte_i] : SBOX_FWD[byte_i];

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Time-multiplexed SubBytes/InvSubBytes: NUM_SBOX lanes walk the state word
// over BEATS cycles, then hold the full result on a valid/ready port.
module aes_sub_bytes_seq
   import aes_pkg::*;
#(
   parameter int NUM_BYTES = 16,
   parameter int NUM_SBOX  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_inv,
   input  logic [8*NUM_BYTES-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_inv,
   output logic [8*NUM_BYTES-1:0] out_data,
   output logic                   busy
);

   localparam int BEATS = NUM_BYTES / NUM_SBOX;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   if (NUM_BYTES < 1 || (NUM_BYTES % NUM_SBOX) != 0) begin : g_bad_cfg
      $error("aes_sub_bytes_seq: NUM_SBOX must divide NUM_BYTES and NUM_BYTES >= 1");
   end

   // Word stored as [beat][lane][bit] so a beat selects one lane group directly.
   state_t                                   state_q;
   logic [CW-1:0]                            beat_q;
   logic [BEATS-1:0][NUM_SBOX-1:0][7:0]      src_q;
   logic [BEATS-1:0][NUM_SBOX-1:0][7:0]      res_q, res_d;
   logic                                     mode_q;
   logic [NUM_SBOX-1:0][7:0]                 lane_out;

   for (genvar k = 0; k < NUM_SBOX; k++) begin : g_lane
      aes_sbox_lane u_lane (
         .byte_i (src_q[beat_q][k]),
         .inv_i  (mode_q),
         .byte_o (lane_out[k])
      );
   end

   // Merge this beat's lane results into the result word.
   always_comb begin
      res_d = res_q;
      if (state_q == SUB) res_d[beat_q] = lane_out;
   end

   // Control FSM with beat counter and word/mode capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         src_q   <= '0;
         res_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         res_q <= res_d;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  src_q   <= in_data;
                  mode_q  <= in_inv;
                  beat_q  <= '0;
                  state_q <= SUB;
               end
            end
            SUB: begin
               if (beat_q == LAST) begin
                  beat_q  <= '0;
                  state_q <= DONE;
               end else begin
                  beat_q  <= beat_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  if (in_valid) begin
                     src_q   <= in_data;
                     mode_q  <= in_inv;
                     beat_q  <= '0;
                     state_q <= SUB;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A finishing result frees the input side in the same cycle it is taken.
   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == SUB);
   // Partial results are never visible outside DONE.
   assign out_data  = (state_q == DONE) ? res_q : '0;
   assign out_inv   = (state_q == DONE) ? mode_q : 1'b0;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Scoreboard bench for aes_sub_bytes_seq: three configurations (BEATS 4/1/16).
module tb_aes_sub_bytes_seq;
   import aes_pkg::*;

   localparam int W = 128;

   typedef struct {
      int           id;
      logic [W-1:0] data;
      logic         inv;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   in_valid, in_ready, in_inv, out_valid, out_ready, out_inv, busy;
   logic [W-1:0] in_data [3];
   logic [W-1:0] out_data [3];

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_sub_bytes_seq #(.NUM_BYTES(16), .NUM_SBOX(4)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_inv(in_inv[0]),
      .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_inv(out_inv[0]),
      .out_data(out_data[0]), .busy(busy[0]));
   aes_sub_bytes_seq #(.NUM_BYTES(16), .NUM_SBOX(16)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_inv(in_inv[1]),
      .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_inv(out_inv[1]),
      .out_data(out_data[1]), .busy(busy[1]));
   aes_sub_bytes_seq #(.NUM_BYTES(16), .NUM_SBOX(1)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_inv(in_inv[2]),
      .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_inv(out_inv[2]),
      .out_data(out_data[2]), .busy(busy[2]));

   // Hand-computed directed vectors.
   localparam logic [W-1:0] VEC_A   = 128'hffffffffffffffffffffffffff530100;
   localparam logic [W-1:0] VEC_A_F = 128'h16161616161616161616161616ed7c63;
   localparam logic [W-1:0] VEC_B   = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [W-1:0] VEC_B_F = 128'h76abd7fe2b670130c56f6bf27b777c63;
   localparam logic [W-1:0] VEC_B_I = 128'hfbd7f3819ea340bf38a53630d56a0952;

   // Monitor: every handshaked result is popped and compared.
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         if (!rst && out_valid[i] && out_ready[i]) begin
            n_chk++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL sb_unexpected dut%0d: got %h inv %0b, required no output", i, out_data[i], out_inv[i]);
            end else begin
               e = sb.pop_front();
               if (e.id != i || out_data[i] !== e.data || out_inv[i] !== e.inv) begin
                  n_err++;
                  $display("FAIL sb_result dut%0d: got %h inv %0b, required dut%0d %h inv %0b",
                           i, out_data[i], out_inv[i], e.id, e.data, e.inv);
               end
            end
         end
      end
   end

   task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, got, exp);
      end
   endtask

   // Present a word from posedge+1 until accepted; returns the accept edge.
   task automatic send(input int id, input logic [W-1:0] d, input logic inv,
                       input logic [W-1:0] exp, output int t_acc);
      bit ok = 0;
      in_valid[id] = 1'b1;
      in_data[id]  = d;
      in_inv[id]   = inv;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready[id]) begin ok = 1; break; end
      end
      if (!ok) begin
         n_chk++; n_err++;
         $display("FAIL send_timeout dut%0d: in_ready never rose", id);
      end
      sb.push_back('{id, exp, inv});
      t_acc = cyc + 1;
      @(posedge clk); #1;
      in_valid[id] = 1'b0;
   endtask

   task automatic wait_valid(input int id, input int t, input int beats, input string nm);
      bit ok = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (out_valid[id]) begin ok = 1; break; end
      end
      n_chk++;
      if (!ok || cyc != t + beats) begin
         n_err++;
         $display("FAIL %s_latency: out_valid at cycle %0d, required %0d", nm, ok ? cyc : -1, t + beats);
      end
      @(posedge clk); #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
      if (sb.size() != 0) begin
         n_chk++; n_err++;
         $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [W-1:0] ramp(input int w);
      logic [W-1:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'(w * 16 + i);
      return r;
   endfunction

   function automatic logic [W-1:0] tbl(input int w, input bit inv);
      logic [W-1:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? SBOX_INV[w * 16 + i] : SBOX_FWD[w * 16 + i];
      return r;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  t;
      bit  stale;
      bit  tbl_ok;
      rst = 1'b1;
      in_valid = '0; in_inv = '0; out_ready = '1;
      for (int i = 0; i < 3; i++) in_data[i] = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_in_ready",  W'(in_ready[0]),  W'(1));
      check("rst_out_valid", W'(out_valid[0]), W'(0));
      check("rst_busy",      W'(busy[0]),      W'(0));
      check("rst_out_inv",   W'(out_inv[0]),   W'(0));
      check("rst_out_data",  out_data[0],      '0);
      @(posedge clk); #1;

      // Forward then inverse round trip, BEATS=4
      send(0, VEC_A, 1'b0, VEC_A_F, t);
      @(negedge clk);
      check("sub_busy", W'(busy[0]), W'(1));
      check("sub_in_ready", W'(in_ready[0]), W'(0));
      wait_valid(0, t, 4, "fwd");
      send(0, VEC_A_F, 1'b1, VEC_A, t);
      wait_valid(0, t, 4, "inv");
      drain();

      // Backpressure: hold result 10 cycles while a new word waits
      out_ready[0] = 1'b0;
      send(0, VEC_A, 1'b0, VEC_A_F, t);
      wait_valid(0, t, 4, "bp");
      in_valid[0] = 1'b1; in_data[0] = VEC_A_F; in_inv[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("bp_out_valid", W'(out_valid[0]), W'(1));
         check("bp_out_data",  out_data[0],      VEC_A_F);
         check("bp_in_ready",  W'(in_ready[0]),  W'(0));
      end
      @(posedge clk); #1;
      out_ready[0] = 1'b1;
      sb.push_back('{0, VEC_A, 1'b1});
      @(negedge clk);
      check("bp_release_in_ready", W'(in_ready[0]), W'(1));
      t = cyc + 1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      @(negedge clk);
      check("bp_accept_busy", W'(busy[0]), W'(1));
      @(posedge clk); #1;
      wait_valid(0, t, 4, "bp_next");
      drain();

      // Reset during beat 2 drops the word
      send(0, VEC_A, 1'b0, VEC_A_F, t);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      void'(sb.pop_back());
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_out_valid", W'(out_valid[0]), W'(0));
      check("mid_rst_out_data",  out_data[0],      '0);
      check("mid_rst_in_ready",  W'(in_ready[0]),  W'(1));
      @(posedge clk); #1 rst = 1'b0;
      stale = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (out_valid[0]) stale = 1;
      end
      check("mid_rst_no_stale", W'(stale), W'(0));
      @(posedge clk); #1;

      // Tables are mutual inverses
      tbl_ok = 1;
      for (int x = 0; x < 256; x++) begin
         logic [7:0] f;
         f = SBOX_FWD[x];
         if (SBOX_INV[f] != 8'(x)) tbl_ok = 0;
      end
      check("tbl_inverse", W'(tbl_ok), W'(1));

      // Exhaustive, BEATS=1
      for (int w = 0; w < 16; w++) begin
         for (int m = 0; m < 2; m++) begin
            send(1, ramp(w), m[0], tbl(w, m[0]), t);
            wait_valid(1, t, 1, "bx");
         end
      end
      drain();

      // NUM_SBOX=1: alternating mode, then back-to-back mode change
      send(2, VEC_B, 1'b0, VEC_B_F, t);
      wait_valid(2, t, 16, "s1_fwd");
      send(2, VEC_B, 1'b1, VEC_B_I, t);
      wait_valid(2, t, 16, "s1_inv");
      send(2, VEC_B, 1'b0, VEC_B_F, t);
      send(2, VEC_B, 1'b1, VEC_B_I, t);
      wait_valid(2, t, 16, "s1_b2b");
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
